// File: rtl/rob_commit.sv
// rtl/rob_commit.sv - reorder-buffer retirement: head/tail/count ownership and in-order commit
module rob_commit #(
  parameter int ROB_SIZE = 16,
  parameter int TAG_W    = $clog2(ROB_SIZE) + 1,
  parameter int DATA_W   = 32,
  parameter int REG_W    = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rob_increment,
  input  logic              i_head_ready,
  input  logic              i_head_regwr,
  input  logic              i_head_memwr,
  input  logic              i_head_ecall,
  input  logic              i_head_unsupported,
  input  logic              i_head_mispredict,
  input  logic [REG_W-1:0]  i_head_rd,
  input  logic [DATA_W-1:0] i_head_value,
  input  logic [TAG_W-1:0]  i_map_tag_of_rd,
  input  logic              i_st_ack,
  output logic [TAG_W-1:0]  o_rob_head,
  output logic [TAG_W-1:0]  o_rob_tail,
  output logic [TAG_W-1:0]  o_rob_count,
  output logic              o_rf_we,
  output logic [REG_W-1:0]  o_rf_waddr,
  output logic [DATA_W-1:0] o_rf_wdata,
  output logic              o_mt_clear,
  output logic              o_st_commit,
  output logic              o_flush,
  output logic [DATA_W-1:0] o_redirect_pc,
  output logic              o_retired,
  output logic              o_halted
);

  localparam logic [TAG_W-1:0] LP_SIZE = TAG_W'(ROB_SIZE);
  localparam logic [TAG_W-1:0] LP_ONE  = TAG_W'(1);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_STORE_WAIT = 2'd1,
    ST_HALT       = 2'd2
  } state_t;

  // Tags are 1-based, so the pointer wraps from ROB_SIZE back to 1
  function automatic logic [TAG_W-1:0] f_next(input logic [TAG_W-1:0] p);
    return (p == LP_SIZE) ? LP_ONE : p + LP_ONE;
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic [TAG_W-1:0]    r_head;
  logic [TAG_W-1:0]    r_tail;
  logic [TAG_W-1:0]    r_count;
  logic                r_rf_we;
  logic [REG_W-1:0]    r_rf_waddr;
  logic [DATA_W-1:0]   r_rf_wdata;
  logic                r_mt_clear;
  logic                r_st_commit;
  logic                r_flush;
  logic [DATA_W-1:0]   r_redirect_pc;
  logic                r_retired;
  logic                r_halted;

  logic                w_head_valid;
  logic                w_wr_ok;
  logic                w_tag_match;
  logic                w_alloc;
  logic                w_retire;
  logic                w_rf_we_nxt;
  logic [REG_W-1:0]    w_rf_waddr_nxt;
  logic [DATA_W-1:0]   w_rf_wdata_nxt;
  logic                w_mt_clear_nxt;
  logic                w_st_commit_nxt;
  logic                w_flush_nxt;
  logic [DATA_W-1:0]   w_redirect_pc_nxt;
  logic                w_halted_nxt;

  assign w_head_valid = (r_count != '0) && i_head_ready;
  // x0 is hard-wired zero, so it is never written and never has a map entry to release
  assign w_wr_ok      = i_head_regwr && (i_head_rd != '0);
  // Only release the mapping if no younger instruction has since claimed the register
  assign w_tag_match  = (i_map_tag_of_rd == r_head);
  // A full ROB silently drops the allocation request
  assign w_alloc      = i_rob_increment && (r_count != LP_SIZE);

  // State register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decision from the head entry and the LSQ handshake
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_head_valid) begin
          if (i_head_ecall || i_head_unsupported) begin
            w_state_nxt = ST_HALT;
          end else if (i_head_mispredict) begin
            w_state_nxt = ST_RUN;
          end else if (i_head_memwr) begin
            w_state_nxt = ST_STORE_WAIT;
          end
        end
      end
      ST_STORE_WAIT: begin
        if (i_st_ack) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Next values of the registered commit outputs; pulses default low, data fields hold
  always_comb begin
    w_retire          = 1'b0;
    w_rf_we_nxt       = 1'b0;
    w_rf_waddr_nxt    = r_rf_waddr;
    w_rf_wdata_nxt    = r_rf_wdata;
    w_mt_clear_nxt    = 1'b0;
    w_st_commit_nxt   = 1'b0;
    w_flush_nxt       = 1'b0;
    w_redirect_pc_nxt = r_redirect_pc;
    w_halted_nxt      = r_halted;
    case (r_state)
      ST_RUN: begin
        if (w_head_valid) begin
          if (i_head_ecall || i_head_unsupported) begin
            w_retire     = 1'b1;
            w_halted_nxt = 1'b1;
          end else if (i_head_mispredict) begin
            w_retire          = 1'b1;
            w_flush_nxt       = 1'b1;
            w_redirect_pc_nxt = i_head_value;
            if (w_wr_ok) begin
              w_rf_we_nxt    = 1'b1;
              w_rf_waddr_nxt = i_head_rd;
              w_rf_wdata_nxt = i_head_value;
              w_mt_clear_nxt = w_tag_match;
            end
          end else if (i_head_memwr) begin
            w_st_commit_nxt = 1'b1;
          end else begin
            w_retire = 1'b1;
            if (w_wr_ok) begin
              w_rf_we_nxt    = 1'b1;
              w_rf_waddr_nxt = i_head_rd;
              w_rf_wdata_nxt = i_head_value;
              w_mt_clear_nxt = w_tag_match;
            end
          end
        end
      end
      ST_STORE_WAIT: begin
        // Keep offering the store until the LSQ takes it, then retire it
        w_st_commit_nxt = !i_st_ack;
        w_retire        = i_st_ack;
      end
      default: begin
        w_retire = 1'b0;
      end
    endcase
  end

  // Pointer/count bookkeeping; a flush empties the ROB and drops any same-cycle allocation
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_head  <= LP_ONE;
      r_tail  <= LP_ONE;
      r_count <= '0;
    end else if (w_flush_nxt) begin
      r_head  <= LP_ONE;
      r_tail  <= LP_ONE;
      r_count <= '0;
    end else begin
      if (w_retire) r_head <= f_next(r_head);
      if (w_alloc)  r_tail <= f_next(r_tail);
      case ({w_alloc, w_retire})
        2'b10:   r_count <= r_count + LP_ONE;
        2'b01:   r_count <= r_count - LP_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Output registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_rf_we       <= 1'b0;
      r_rf_waddr    <= '0;
      r_rf_wdata    <= '0;
      r_mt_clear    <= 1'b0;
      r_st_commit   <= 1'b0;
      r_flush       <= 1'b0;
      r_redirect_pc <= '0;
      r_retired     <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_rf_we       <= w_rf_we_nxt;
      r_rf_waddr    <= w_rf_waddr_nxt;
      r_rf_wdata    <= w_rf_wdata_nxt;
      r_mt_clear    <= w_mt_clear_nxt;
      r_st_commit   <= w_st_commit_nxt;
      r_flush       <= w_flush_nxt;
      r_redirect_pc <= w_redirect_pc_nxt;
      r_retired     <= w_retire;
      r_halted      <= w_halted_nxt;
    end
  end

  assign o_rob_head    = r_head;
  assign o_rob_tail    = r_tail;
  assign o_rob_count   = r_count;
  assign o_rf_we       = r_rf_we;
  assign o_rf_waddr    = r_rf_waddr;
  assign o_rf_wdata    = r_rf_wdata;
  assign o_mt_clear    = r_mt_clear;
  assign o_st_commit   = r_st_commit;
  assign o_flush       = r_flush;
  assign o_redirect_pc = r_redirect_pc;
  assign o_retired     = r_retired;
  assign o_halted      = r_halted;

endmodule

// File: tb/tb_rob_commit.sv
// tb/tb_rob_commit.sv - directed self-checking bench for rob_commit
`timescale 1ns/1ps
module tb_rob_commit;

  logic        i_clk;
  logic        i_reset;
  logic        i_rob_increment;
  logic        i_head_ready;
  logic        i_head_regwr;
  logic        i_head_memwr;
  logic        i_head_ecall;
  logic        i_head_unsupported;
  logic        i_head_mispredict;
  logic [4:0]  i_head_rd;
  logic [31:0] i_head_value;
  logic [4:0]  i_map_tag_of_rd;
  logic        i_st_ack;
  logic [4:0]  o_rob_head;
  logic [4:0]  o_rob_tail;
  logic [4:0]  o_rob_count;
  logic        o_rf_we;
  logic [4:0]  o_rf_waddr;
  logic [31:0] o_rf_wdata;
  logic        o_mt_clear;
  logic        o_st_commit;
  logic        o_flush;
  logic [31:0] o_redirect_pc;
  logic        o_retired;
  logic        o_halted;

  int checks;
  int failures;

  rob_commit #(.ROB_SIZE(16), .TAG_W(5), .DATA_W(32), .REG_W(5)) dut (
    .i_clk              (i_clk),
    .i_reset            (i_reset),
    .i_rob_increment    (i_rob_increment),
    .i_head_ready       (i_head_ready),
    .i_head_regwr       (i_head_regwr),
    .i_head_memwr       (i_head_memwr),
    .i_head_ecall       (i_head_ecall),
    .i_head_unsupported (i_head_unsupported),
    .i_head_mispredict  (i_head_mispredict),
    .i_head_rd          (i_head_rd),
    .i_head_value       (i_head_value),
    .i_map_tag_of_rd    (i_map_tag_of_rd),
    .i_st_ack           (i_st_ack),
    .o_rob_head         (o_rob_head),
    .o_rob_tail         (o_rob_tail),
    .o_rob_count        (o_rob_count),
    .o_rf_we            (o_rf_we),
    .o_rf_waddr         (o_rf_waddr),
    .o_rf_wdata         (o_rf_wdata),
    .o_mt_clear         (o_mt_clear),
    .o_st_commit        (o_st_commit),
    .o_flush            (o_flush),
    .o_redirect_pc      (o_redirect_pc),
    .o_retired          (o_retired),
    .o_halted           (o_halted)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_rob_increment    = 1'b0;
    i_head_ready       = 1'b0;
    i_head_regwr       = 1'b0;
    i_head_memwr       = 1'b0;
    i_head_ecall       = 1'b0;
    i_head_unsupported = 1'b0;
    i_head_mispredict  = 1'b0;
    i_head_rd          = 5'd0;
    i_head_value       = 32'd0;
    i_map_tag_of_rd    = 5'd0;
    i_st_ack           = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    i_reset = 1'b0;
    tick();
    i_reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    i_reset = 1'b0;
    tick();
    tick();
    checks++;
    if ({o_rob_head, o_rob_tail, o_rob_count} !== {5'd1, 5'd1, 5'd0}) begin
      failures++;
      $display("FAIL reset_ptrs head=%0d tail=%0d count=%0d expected 1 1 0", o_rob_head, o_rob_tail, o_rob_count);
    end
    checks++;
    if ({o_rf_we, o_mt_clear, o_st_commit, o_flush, o_retired, o_halted} !== 6'b0) begin
      failures++;
      $display("FAIL reset_strobes got %b expected 000000", {o_rf_we, o_mt_clear, o_st_commit, o_flush, o_retired, o_halted});
    end
    checks++;
    if ({o_rf_waddr, o_rf_wdata, o_redirect_pc} !== 69'd0) begin
      failures++;
      $display("FAIL reset_data waddr=%0d wdata=%h redirect=%h expected 0", o_rf_waddr, o_rf_wdata, o_redirect_pc);
    end
    i_reset = 1'b1;
    tick();
  endtask

  task automatic test_alloc_retire();
    i_rob_increment = 1'b1;
    repeat (3) tick();
    i_rob_increment = 1'b0;
    checks++;
    if ({o_rob_tail, o_rob_count} !== {5'd4, 5'd3}) begin
      failures++;
      $display("FAIL alloc3 tail=%0d count=%0d expected 4 3", o_rob_tail, o_rob_count);
    end
    i_head_ready = 1'b1; i_head_regwr = 1'b1; i_head_rd = 5'd5;
    i_head_value = 32'h1234; i_map_tag_of_rd = 5'd1;
    tick();
    clear_inputs();
    checks++;
    if ({o_rf_we, o_rf_waddr, o_rf_wdata, o_mt_clear, o_retired} !== {1'b1, 5'd5, 32'h1234, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL retire_write we=%b waddr=%0d wdata=%h mt=%b ret=%b expected 1 5 1234 1 1",
               o_rf_we, o_rf_waddr, o_rf_wdata, o_mt_clear, o_retired);
    end
    checks++;
    if ({o_rob_head, o_rob_count} !== {5'd2, 5'd2}) begin
      failures++;
      $display("FAIL retire_ptrs head=%0d count=%0d expected 2 2", o_rob_head, o_rob_count);
    end
    tick();
    checks++;
    if ({o_rf_we, o_mt_clear, o_retired} !== 3'b000) begin
      failures++;
      $display("FAIL pulse_width we=%b mt=%b ret=%b expected 000", o_rf_we, o_mt_clear, o_retired);
    end
  endtask

  task automatic test_younger_writer();
    i_head_ready = 1'b1; i_head_regwr = 1'b1; i_head_rd = 5'd7;
    i_head_value = 32'hBEEF; i_map_tag_of_rd = 5'd3;
    tick();
    clear_inputs();
    checks++;
    if ({o_rf_we, o_rf_waddr, o_mt_clear, o_rob_head, o_rob_count} !== {1'b1, 5'd7, 1'b0, 5'd3, 5'd1}) begin
      failures++;
      $display("FAIL younger_writer we=%b waddr=%0d mt=%b head=%0d count=%0d expected 1 7 0 3 1",
               o_rf_we, o_rf_waddr, o_mt_clear, o_rob_head, o_rob_count);
    end
    i_head_ready = 1'b1; i_head_regwr = 1'b1; i_head_rd = 5'd0;
    i_head_value = 32'hDEAD; i_map_tag_of_rd = 5'd3;
    tick();
    clear_inputs();
    checks++;
    if ({o_rf_we, o_mt_clear, o_retired, o_rob_head, o_rob_count} !== {1'b0, 1'b0, 1'b1, 5'd4, 5'd0}) begin
      failures++;
      $display("FAIL write_x0 we=%b mt=%b ret=%b head=%0d count=%0d expected 0 0 1 4 0",
               o_rf_we, o_mt_clear, o_retired, o_rob_head, o_rob_count);
    end
  endtask

  task automatic test_fill_wrap();
    do_reset();
    i_rob_increment = 1'b1;
    repeat (16) tick();
    checks++;
    if ({o_rob_tail, o_rob_count} !== {5'd1, 5'd16}) begin
      failures++;
      $display("FAIL fill16 tail=%0d count=%0d expected 1 16", o_rob_tail, o_rob_count);
    end
    tick();
    i_rob_increment = 1'b0;
    checks++;
    if ({o_rob_tail, o_rob_count} !== {5'd1, 5'd16}) begin
      failures++;
      $display("FAIL alloc_when_full tail=%0d count=%0d expected 1 16", o_rob_tail, o_rob_count);
    end
    i_head_ready = 1'b1;
    repeat (15) tick();
    checks++;
    if ({o_rob_head, o_rob_count} !== {5'd16, 5'd1}) begin
      failures++;
      $display("FAIL retire15 head=%0d count=%0d expected 16 1", o_rob_head, o_rob_count);
    end
    tick();
    i_head_ready = 1'b0;
    checks++;
    if ({o_rob_head, o_rob_count} !== {5'd1, 5'd0}) begin
      failures++;
      $display("FAIL head_wrap head=%0d count=%0d expected 1 0", o_rob_head, o_rob_count);
    end
    i_rob_increment = 1'b1;
    repeat (2) tick();
    i_head_ready = 1'b1;
    tick();
    clear_inputs();
    checks++;
    if ({o_rob_head, o_rob_tail, o_rob_count, o_retired} !== {5'd2, 5'd4, 5'd2, 1'b1}) begin
      failures++;
      $display("FAIL alloc_and_retire head=%0d tail=%0d count=%0d ret=%b expected 2 4 2 1",
               o_rob_head, o_rob_tail, o_rob_count, o_retired);
    end
  endtask

  task automatic test_store();
    do_reset();
    i_rob_increment = 1'b1;
    tick();
    i_rob_increment = 1'b0;
    i_head_ready = 1'b1; i_head_memwr = 1'b1; i_head_regwr = 1'b1; i_head_rd = 5'd6;
    tick();
    checks++;
    if ({o_st_commit, o_retired, o_rf_we, o_rob_head, o_rob_count} !== {1'b1, 1'b0, 1'b0, 5'd1, 5'd1}) begin
      failures++;
      $display("FAIL store_start stc=%b ret=%b we=%b head=%0d count=%0d expected 1 0 0 1 1",
               o_st_commit, o_retired, o_rf_we, o_rob_head, o_rob_count);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({o_st_commit, o_retired, o_rob_head} !== {1'b1, 1'b0, 5'd1}) begin
        failures++;
        $display("FAIL store_hold%0d stc=%b ret=%b head=%0d expected 1 0 1", i, o_st_commit, o_retired, o_rob_head);
      end
    end
    i_st_ack = 1'b1;
    tick();
    clear_inputs();
    checks++;
    if ({o_st_commit, o_retired, o_rf_we, o_rob_head, o_rob_count} !== {1'b0, 1'b1, 1'b0, 5'd2, 5'd0}) begin
      failures++;
      $display("FAIL store_ack stc=%b ret=%b we=%b head=%0d count=%0d expected 0 1 0 2 0",
               o_st_commit, o_retired, o_rf_we, o_rob_head, o_rob_count);
    end
  endtask

  task automatic test_mispredict();
    i_rob_increment = 1'b1;
    repeat (3) tick();
    checks++;
    if ({o_rob_tail, o_rob_count} !== {5'd5, 5'd3}) begin
      failures++;
      $display("FAIL mp_alloc tail=%0d count=%0d expected 5 3", o_rob_tail, o_rob_count);
    end
    i_head_ready = 1'b1; i_head_mispredict = 1'b1; i_head_value = 32'h400;
    i_head_regwr = 1'b1; i_head_rd = 5'd3;
    tick();
    clear_inputs();
    checks++;
    if ({o_flush, o_redirect_pc, o_retired} !== {1'b1, 32'h400, 1'b1}) begin
      failures++;
      $display("FAIL mp_flush flush=%b redirect=%h ret=%b expected 1 400 1", o_flush, o_redirect_pc, o_retired);
    end
    checks++;
    if ({o_rob_head, o_rob_tail, o_rob_count} !== {5'd1, 5'd1, 5'd0}) begin
      failures++;
      $display("FAIL mp_ptrs head=%0d tail=%0d count=%0d expected 1 1 0", o_rob_head, o_rob_tail, o_rob_count);
    end
    checks++;
    if ({o_rf_we, o_rf_waddr, o_rf_wdata} !== {1'b1, 5'd3, 32'h400}) begin
      failures++;
      $display("FAIL mp_write we=%b waddr=%0d wdata=%h expected 1 3 400", o_rf_we, o_rf_waddr, o_rf_wdata);
    end
    tick();
    checks++;
    if ({o_flush, o_rob_count} !== {1'b0, 5'd0}) begin
      failures++;
      $display("FAIL mp_after flush=%b count=%0d expected 0 0", o_flush, o_rob_count);
    end
  endtask

  task automatic test_halt();
    i_rob_increment = 1'b1;
    repeat (2) tick();
    i_rob_increment = 1'b0;
    i_head_ready = 1'b1; i_head_ecall = 1'b1;
    tick();
    i_head_ecall = 1'b0;
    checks++;
    if ({o_halted, o_retired, o_rf_we, o_rob_head, o_rob_count} !== {1'b1, 1'b1, 1'b0, 5'd2, 5'd1}) begin
      failures++;
      $display("FAIL ecall halted=%b ret=%b we=%b head=%0d count=%0d expected 1 1 0 2 1",
               o_halted, o_retired, o_rf_we, o_rob_head, o_rob_count);
    end
    i_head_regwr = 1'b1; i_head_rd = 5'd4; i_head_value = 32'h77; i_map_tag_of_rd = 5'd2;
    repeat (3) tick();
    checks++;
    if ({o_halted, o_retired, o_rf_we, o_rob_head, o_rob_count} !== {1'b1, 1'b0, 1'b0, 5'd2, 5'd1}) begin
      failures++;
      $display("FAIL halt_sticky halted=%b ret=%b we=%b head=%0d count=%0d expected 1 0 0 2 1",
               o_halted, o_retired, o_rf_we, o_rob_head, o_rob_count);
    end
    clear_inputs();
    i_rob_increment = 1'b1;
    tick();
    i_rob_increment = 1'b0;
    checks++;
    if ({o_rob_tail, o_rob_count, o_halted} !== {5'd4, 5'd2, 1'b1}) begin
      failures++;
      $display("FAIL halt_alloc tail=%0d count=%0d halted=%b expected 4 2 1", o_rob_tail, o_rob_count, o_halted);
    end
  endtask

  task automatic test_reset_in_store_wait();
    do_reset();
    i_rob_increment = 1'b1;
    repeat (2) tick();
    i_rob_increment = 1'b0;
    i_head_ready = 1'b1; i_head_memwr = 1'b1;
    tick();
    tick();
    checks++;
    if (o_st_commit !== 1'b1) begin
      failures++;
      $display("FAIL sw_entry stc=%b expected 1", o_st_commit);
    end
    #3;
    i_reset = 1'b0;
    #1;
    checks++;
    if ({o_st_commit, o_rob_head, o_rob_tail, o_rob_count, o_halted, o_retired} !==
        {1'b0, 5'd1, 5'd1, 5'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset stc=%b head=%0d tail=%0d count=%0d halted=%b ret=%b expected 0 1 1 0 0 0",
               o_st_commit, o_rob_head, o_rob_tail, o_rob_count, o_halted, o_retired);
    end
    clear_inputs();
    tick();
    i_reset = 1'b1;
    i_rob_increment = 1'b1;
    tick();
    i_rob_increment = 1'b0;
    i_head_ready = 1'b1; i_head_regwr = 1'b1; i_head_rd = 5'd9;
    i_head_value = 32'h55; i_map_tag_of_rd = 5'd1;
    tick();
    clear_inputs();
    checks++;
    if ({o_rf_we, o_rf_waddr, o_rf_wdata, o_retired, o_st_commit, o_rob_head} !==
        {1'b1, 5'd9, 32'h55, 1'b1, 1'b0, 5'd2}) begin
      failures++;
      $display("FAIL run_after_reset we=%b waddr=%0d wdata=%h ret=%b stc=%b head=%0d expected 1 9 55 1 0 2",
               o_rf_we, o_rf_waddr, o_rf_wdata, o_retired, o_st_commit, o_rob_head);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    i_reset  = 1'b0;
    clear_inputs();
    test_reset();
    test_alloc_retire();
    test_younger_writer();
    test_fill_wrap();
    test_store();
    test_mispredict();
    test_halt();
    test_reset_in_store_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
